// File: rtl/pgpmem_pack.sv
// pgpmem_pack: packs PACK DW-bit writes into one wide word, buffers through a FIFO and drains one word per cycle to SPRAM; reads return after RDLAT cycles.
// ready drops at BUFDEPTH/2 queued words; a push into a full FIFO is dropped and flags err_overflow. `PGPMEM_PACK_WORDSWAP_EN stores lane 0 at the MSB.
module pgpmem_pack_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push_i,
  input  logic [W-1:0]            dat_i,
  input  logic                    pop_i,
  output logic [W-1:0]            dat_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  count_next_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == (PW+1)'(DEPTH));
  assign wr_en        = push_i & ~full_o;
  assign rd_en        = pop_i & ~empty_o;
  assign dat_o        = mem_q[rd_ptr_q];
  assign count_next_o = count_d;

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (rd_en && !wr_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= dat_i;
  end
endmodule

module pgpmem_pack #(
  parameter int DW       = 16,
  parameter int PACK     = 2,
  parameter int DEPTH    = 4096,
  parameter int BUFDEPTH = 32,
  parameter int RDLAT    = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wrreq,
  input  logic [$clog2(DEPTH)-1:0] wraddress,
  input  logic [DW-1:0]            d,
  input  logic                     flush,
  output logic                     ready,
  input  logic                     rdreq,
  input  logic [$clog2(DEPTH)-1:0] rdaddress,
  output logic [DW*PACK-1:0]       q,
  output logic                     q_valid,
  output logic                     err_misalign,
  output logic                     err_overflow
);
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = $clog2(PACK);
  localparam int CW     = (PACK > 1) ? LW : 1;
  localparam int WAW    = AW - LW;
  localparam int WW     = DW * PACK;
  localparam int CNTW   = $clog2(BUFDEPTH) + 1;

  logic [CW-1:0]   lane_q, lane_d;
  logic [WAW-1:0]  base_q, base_d, push_addr;
  logic [WW-1:0]   pack_q, pack_d, merged;
  logic            ready_q, mis_q, ovf_q;
  logic            lane0_wr, last_lane, push, bad_addr;
  logic [AW-1:0]   lane_addr;
  logic            drain, fifo_empty, fifo_full;
  logic [WAW+WW-1:0] fifo_dat;
  logic [CNTW-1:0] fifo_cnt_d;

  assign lane0_wr  = wrreq && (lane_q == '0);
  assign last_lane = wrreq && (lane_q == CW'(PACK-1));
  assign push      = last_lane || (flush && (wrreq || lane_q != '0));
  assign push_addr = lane0_wr ? WAW'(wraddress >> LW) : base_q;
  assign lane_addr = (AW'(base_q) << LW) | AW'(lane_q);
  // A misaligned write still lands in the current lane at the captured base.
  assign bad_addr  = lane0_wr ? ((wraddress & AW'(PACK-1)) != '0) : (wraddress != lane_addr);

  always_comb begin
    merged = pack_q;
    if (wrreq) merged[lane_q*DW +: DW] = d;
  end

  always_comb begin
    lane_d = lane_q;
    base_d = base_q;
    pack_d = merged;
    if (lane0_wr) base_d = push_addr;
    if (push) begin
      lane_d = '0;
      pack_d = '0;
    end else if (wrreq) begin
      lane_d = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane_q  <= '0;
      base_q  <= '0;
      pack_q  <= '0;
      mis_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      lane_q  <= lane_d;
      base_q  <= base_d;
      pack_q  <= pack_d;
      mis_q   <= mis_q | (wrreq & bad_addr);
      ovf_q   <= ovf_q | (push & fifo_full);
      ready_q <= (fifo_cnt_d < CNTW'(BUFDEPTH/2));
    end
  end

  pgpmem_pack_fifo #(.W(WAW+WW), .DEPTH(BUFDEPTH)) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (push),
    .dat_i        ({push_addr, merged}),
    .pop_i        (drain),
    .dat_o        (fifo_dat),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .count_next_o (fifo_cnt_d)
  );

  assign drain = ~fifo_empty;

  logic           st_vld_q;
  logic [WAW-1:0] st_addr_q;
  logic [WW-1:0]  st_dat_q;
  logic           mem_we;
  logic [WAW-1:0] mem_wa;
  logic [WW-1:0]  mem_wd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_vld_q  <= 1'b0;
      st_addr_q <= '0;
      st_dat_q  <= '0;
    end else begin
      st_vld_q <= drain;
      if (drain) {st_addr_q, st_dat_q} <= fifo_dat;
    end
  end

`ifdef PGPMEM_PACK_WORDSWAP_EN
  logic           sw_vld_q;
  logic [WAW-1:0] sw_addr_q;
  logic [WW-1:0]  sw_dat_q, rev;

  always_comb begin
    rev = '0;
    for (int i = 0; i < PACK; i++) rev[i*DW +: DW] = st_dat_q[(PACK-1-i)*DW +: DW];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_vld_q  <= 1'b0;
      sw_addr_q <= '0;
      sw_dat_q  <= '0;
    end else begin
      sw_vld_q <= st_vld_q;
      if (st_vld_q) begin
        sw_addr_q <= st_addr_q;
        sw_dat_q  <= rev;
      end
    end
  end

  assign mem_we = sw_vld_q;
  assign mem_wa = sw_addr_q;
  assign mem_wd = sw_dat_q;
`else
  assign mem_we = st_vld_q;
  assign mem_wa = st_addr_q;
  assign mem_wd = st_dat_q;
`endif

  logic [WW-1:0]    spram [DEPTH/PACK];
  logic [RDLAT-1:0] rvld_q;
  logic [WW-1:0]    rdat_q [RDLAT];

  always_ff @(posedge clk) begin
    if (mem_we) spram[mem_wa] <= mem_wd;
  end

  // Read samples the array before the same-edge write lands: old data wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvld_q <= '0;
      for (int i = 0; i < RDLAT; i++) rdat_q[i] <= '0;
    end else begin
      rvld_q[0] <= rdreq;
      if (rdreq) rdat_q[0] <= spram[WAW'(rdaddress >> LW)];
      for (int i = 1; i < RDLAT; i++) begin
        rvld_q[i] <= rvld_q[i-1];
        if (rvld_q[i-1]) rdat_q[i] <= rdat_q[i-1];
      end
    end
  end

  assign q            = rdat_q[RDLAT-1];
  assign q_valid      = rvld_q[RDLAT-1];
  assign ready        = ready_q;
  assign err_misalign = mis_q;
  assign err_overflow = ovf_q;
endmodule
